// File: rtl/clock_group_div_source.sv
// clock_group_div_source
//
// Sourcing end of the clock-group bundle. One reference clock is divided
// down into NUM_DOMAINS domain clocks by toggle division. Each domain has its
// own active-high reset. A domain reset is released only after RESET_CYCLES
// rising edges of that domain's clock, and always on a falling edge. A
// valid/ready config port reprograms one domain's divisor at a time. The
// reprogrammed domain is taken through a glitch-free drain and reset sequence.
//
// Ports:
//   clock        reference clock
//   reset        asynchronous active-high reset
//   cfg_valid    config request
//   cfg_ready    config request can be accepted (low while busy)
//   cfg_domain   target domain index
//   cfg_divisor  new divisor for the target domain (0 behaves as 1)
//   cfg_err      one-cycle pulse after accepting an out-of-range domain
//   busy         a domain is reconfiguring
//   out_clock    divided clocks, bit k = domain k
//   out_reset    domain resets, active-high, bit k = domain k
module clock_group_div_source #(
    parameter int NUM_DOMAINS  = 6,
    parameter int DIV_W        = 8,
    parameter int RESET_CYCLES = 4,
    parameter int DEFAULT_DIV  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [7:0]             cfg_domain,
    input  logic [DIV_W-1:0]       cfg_divisor,
    output logic                   cfg_err,
    output logic                   busy,
    output logic [NUM_DOMAINS-1:0] out_clock,
    output logic [NUM_DOMAINS-1:0] out_reset
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_DONE = RC_W'(RESET_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } dom_state_t;

    logic                   accept;
    logic                   accept_bad;
    logic                   accept_ok;
    logic                   busy_d;
    logic [DIV_W-1:0]       pend_div;
    logic [NUM_DOMAINS-1:0] hold_release;

    assign accept     = cfg_valid && cfg_ready;
    assign accept_bad = accept && (cfg_domain >= 8'(NUM_DOMAINS));
    assign accept_ok  = accept && !accept_bad;

    // An accepted request for a valid domain sets busy. busy clears when that
    // domain releases its reset at the end of HOLD. The two events cannot
    // happen together: an accept needs cfg_ready, and cfg_ready is low while
    // busy is set.
    always_comb begin
        busy_d = busy;
        if (accept_ok) begin
            busy_d = 1'b1;
        end else if (|hold_release) begin
            busy_d = 1'b0;
        end
    end

    // Config-side registers. cfg_ready is computed from the next value of
    // busy, so it drops on the same cycle busy rises and comes back on the
    // release cycle. Only one reconfiguration can be in flight, so a single
    // register holds the pending divisor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            pend_div  <= DIV_W'(DEFAULT_DIV);
        end else begin
            busy      <= busy_d;
            cfg_ready <= !busy_d;
            cfg_err   <= accept_bad;
            if (accept_ok) begin
                pend_div <= cfg_divisor;
            end
        end
    end

    for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] last;
        logic [RC_W-1:0]  rc_q, rc_d;
        logic             clk_q, clk_d;
        logic             rst_q, rst_d;
        logic             start, wrap, rise, fall, release_ok;
        dom_state_t       st_q, st_d;

        assign start      = accept_ok && (cfg_domain == 8'(k));
        // A stored divisor of 0 divides as if it were 1.
        assign last       = (div_q == '0) ? '0 : div_q - DIV_W'(1);
        assign wrap       = (cnt_q == last);
        assign rise       = wrap && !clk_q;
        assign fall       = wrap && clk_q;
        assign release_ok = rst_q && fall && (rc_q == RC_DONE);

        assign hold_release[k] = (st_q == ST_HOLD) && release_ok;
        assign out_clock[k]    = clk_q;
        assign out_reset[k]    = rst_q;

        // Next-state logic for one domain. Toggle division runs in every
        // state. While reset is held, rc counts rising edges of the domain
        // clock. The power-on release happens in RUN under the same rule as
        // a HOLD release. DRAIN only switches the divisor while the clock is
        // low or on its falling toggle, so a high phase is never cut short.
        // A switch also clears rc. That keeps the rc value saturated by the
        // previous release from ending reset early.
        always_comb begin
            cnt_d = cnt_q;
            clk_d = clk_q;
            rc_d  = rc_q;
            rst_d = rst_q;
            div_d = div_q;
            st_d  = st_q;

            if (wrap) begin
                clk_d = ~clk_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            if (rst_q && rise && (rc_q != RC_DONE)) begin
                rc_d = rc_q + RC_W'(1);
            end

            case (st_q)
                ST_RUN: begin
                    if (start) begin
                        rst_d = 1'b1;
                        st_d  = ST_DRAIN;
                    end else if (release_ok) begin
                        rst_d = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!clk_q || fall) begin
                        clk_d = 1'b0;
                        cnt_d = '0;
                        rc_d  = '0;
                        div_d = pend_div;
                        st_d  = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (release_ok) begin
                        rst_d = 1'b0;
                        st_d  = ST_RUN;
                    end
                end
                default: begin
                    st_d = ST_RUN;
                end
            endcase
        end

        // Per-domain state registers. Every domain output comes straight
        // from one of these flops, so out_clock and out_reset have no
        // combinational path from any input.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                clk_q <= 1'b0;
                rc_q  <= '0;
                rst_q <= 1'b1;
                div_q <= DIV_W'(DEFAULT_DIV);
                st_q  <= ST_RUN;
            end else begin
                cnt_q <= cnt_d;
                clk_q <= clk_d;
                rc_q  <= rc_d;
                rst_q <= rst_d;
                div_q <= div_d;
                st_q  <= st_d;
            end
        end
    end

endmodule
